avalon_ring_buffer: RTL and testbench
=====================================

Name: avalon_ring_buffer

Overview:
Parametrised Avalon-MM slave buffer for the Nios II system, DATA_W wide and 2**ADDR_W deep. It has two modes:
- RAM mode: random-access word memory with byte enables.
- FIFO mode: ring buffer accessed through a CSR push/pop port, with occupancy tracking, overflow/underflow flags and a level interrupt.
It sits on the Nios data master as a drop-in replacement for the plain word buffer.

Parameters:
DATA_W, 32, data word width; a multiple of 8.
ADDR_W, 10, log2 of buffer depth (DEPTH = 2**ADDR_W words).
IRQ_DEFAULT, 512, reset value of the interrupt threshold register.

Ports:
clk  in  1  single system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_W+1  word address; MSB=0 selects data window, MSB=1 selects CSR window (low 3 bits decode).
chipselect  in  1  slave select; read/write ignored when low.
read  in  1  read strobe.
write  in  1  write strobe.
byteenable  in  DATA_W/8  per-byte write enable (data window, RAM mode only).
writedata  in  DATA_W  write data.
readdata  out  DATA_W  read data; valid when readdatavalid=1.
readdatavalid  out  1  one-cycle pulse, exactly 1 cycle after an accepted read.
irq  out  1  level interrupt: FIFO mode and count >= THRESH and IE=1.

Behaviour:
- Reset (asynchronous, immediate):
  - readdata=0, readdatavalid=0, irq=0.
  - wr_ptr=0, rd_ptr=0, count=0, MODE=0, IE=0, OVF=0, UDF=0, THRESH=IRQ_DEFAULT.
  - Memory contents are not cleared.
- Access acceptance: chipselect&&write is a write; chipselect&&read&&!write is a read. Write wins if both are asserted. No waitrequest; every access is accepted in its cycle.
- Read latency is fixed at 1: readdata is registered and readdatavalid pulses for one cycle. readdata holds its value between reads.
- Data window, MODE=0:
  - Write updates mem[address[ADDR_W-1:0]] only in the bytes enabled by byteenable.
  - Read returns the whole word.
- Data window, MODE=1: writes are ignored; reads return 0 with readdatavalid still pulsed.
- CSR map (address MSB=1, low 3 bits):
  - 0 CTRL (RW): bit0 MODE, bit1 IE, bit2 FLUSH. FLUSH is write-1, self-clearing, and reads as 0.
  - 1 STATUS (RO): bits[ADDR_W:0] count, bit[ADDR_W+1] EMPTY, bit[ADDR_W+2] FULL, bit[ADDR_W+3] OVF, bit[ADDR_W+4] UDF.
  - 2 THRESH (RW): bits[ADDR_W:0].
  - 3 FLAGS_CLR (W1C): bit0 clears OVF, bit1 clears UDF. Reads as 0.
  - 4 FIFO_DATA: write = push, read = pop.
  - 5..7 are reserved: read as 0, writes ignored.
- Push (MODE=1, write to FIFO_DATA):
  - If not FULL: mem[wr_ptr]<=writedata (all bytes; byteenable ignored), wr_ptr++ modulo DEPTH, count++.
  - If FULL: data is dropped and OVF<=1 (sticky).
- Pop (MODE=1, read of FIFO_DATA):
  - If not EMPTY: readdata<=mem[rd_ptr], rd_ptr++ modulo DEPTH, count--.
  - If EMPTY: readdata<=0 and UDF<=1 (sticky); readdatavalid is still pulsed.
- Push/pop in MODE=0 have no effect. A pop in MODE=0 returns 0.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is ADDR_W+1 bits, range 0..DEPTH. FULL = (count==DEPTH); EMPTY = (count==0).
- FLUSH: wr_ptr, rd_ptr and count return to 0 next cycle. OVF/UDF/MODE/IE/THRESH are unchanged.
- Switching MODE does not alter pointers or count. RAM-mode writes can overwrite queued FIFO data; software is responsible for avoiding this.
- Push and pop are never simultaneous (single slave port); count changes by at most 1 per cycle.
- irq is registered: it updates the cycle after count, THRESH, MODE or IE changes. THRESH=0 with IE=1 in FIFO mode holds irq high.
- Reset asserted mid-transaction aborts it: no readdatavalid is generated after reset deasserts.

Test Plan:
- Reset then RAM mode: write 0xDEADBEEF to addr 5 with byteenable=4'b1111, then write 0x000000AA with byteenable=4'b0001; read addr 5 -> 0xDEADBEAA, readdatavalid exactly 1 cycle after read.
- FIFO mode (CTRL=1): push 1,2,3; STATUS count=3, EMPTY=0; pop x3 -> 1,2,3 in order; STATUS EMPTY=1; a 4th pop -> readdata 0 and UDF=1; FLAGS_CLR=2 -> UDF=0.
- Fill: push 1024 words -> FULL=1, count=1024; push 0xFFFF -> dropped and OVF=1; pop 1024 -> original sequence with no corruption.
- Wrap-around: push 1000, pop 1000, push 50, pop 50 -> data correct; wr_ptr crosses 1023->0.
- Interrupt: THRESH=4, CTRL=3; push 3 -> irq=0; 4th push -> irq=1 the next cycle; pop 1 -> irq=0; FLUSH (CTRL=7) -> count=0 and irq=0.
- Asynchronous reset asserted the cycle after a pop: readdatavalid=0 immediately, count=0, MODE=0, THRESH=512.

Source files
------------

// File: rtl/avalon_ring_buffer.sv
// Avalon-MM slave word buffer: byte-enabled RAM in mode 0, CSR-driven ring FIFO in mode 1.
// Fixed one-cycle read latency; level irq when FIFO occupancy reaches the threshold.
module avalon_ring_buffer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int IRQ_DEFAULT = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W:0]       address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  irq
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W/8;
    localparam int CNT_W  = ADDR_W+1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rdata_q;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, thresh_q, thresh_d;
    logic              mode_q, mode_d, ie_q, ie_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              irq_q, irq_d, rvalid_q, rvalid_d;
    logic              rdsel_mem_q, rdsel_mem_d;
    logic [DATA_W-1:0] csr_rdata_q, csr_rdata_d, csr_rdata;

    logic              wr_acc, rd_acc, csr_sel, full, empty;
    logic              push, pop, push_ok, pop_ok, ram_wr, ram_rd, csr_wr;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [NBYTES-1:0] mem_be;
    logic [2:0]        reg_idx;

    assign wr_acc  = chipselect && write;
    assign rd_acc  = chipselect && read && !write;
    assign csr_sel = address[ADDR_W];
    assign reg_idx = address[2:0];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

    assign ram_wr  = wr_acc && !csr_sel && !mode_q;
    assign ram_rd  = rd_acc && !csr_sel && !mode_q;
    assign csr_wr  = wr_acc && csr_sel;
    assign push    = csr_wr && (reg_idx == 3'd4) && mode_q;
    assign pop     = rd_acc && csr_sel && (reg_idx == 3'd4) && mode_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign mem_we    = ram_wr || push_ok;
    assign mem_re    = ram_rd || pop_ok;
    assign mem_waddr = push_ok ? wr_ptr_q : address[ADDR_W-1:0];
    assign mem_raddr = pop_ok  ? rd_ptr_q : address[ADDR_W-1:0];
    assign mem_be    = push_ok ? '1 : byteenable;

    // Memory has no reset so it maps onto block RAM; its output register only loads on reads.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_waddr][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
        if (mem_re) begin
            mem_rdata_q <= mem[mem_raddr];
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_sel) begin
            case (reg_idx)
                3'd0: begin
                    csr_rdata[0] = mode_q;
                    csr_rdata[1] = ie_q;
                end
                3'd1: begin
                    csr_rdata[CNT_W-1:0] = count_q;
                    csr_rdata[ADDR_W+1]  = empty;
                    csr_rdata[ADDR_W+2]  = full;
                    csr_rdata[ADDR_W+3]  = ovf_q;
                    csr_rdata[ADDR_W+4]  = udf_q;
                end
                3'd2:    csr_rdata[CNT_W-1:0] = thresh_q;
                default: csr_rdata = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        thresh_d    = thresh_q;
        mode_d      = mode_q;
        ie_d        = ie_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        rvalid_d    = rd_acc;
        rdsel_mem_d = rdsel_mem_q;
        csr_rdata_d = csr_rdata_q;
        irq_d       = mode_q && ie_q && (count_q >= thresh_q);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (push && full) ovf_d = 1'b1;
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        if (pop && empty) udf_d = 1'b1;

        if (csr_wr) begin
            case (reg_idx)
                3'd0: begin
                    mode_d = writedata[0];
                    ie_d   = writedata[1];
                    if (writedata[2]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end
                end
                3'd2: thresh_d = writedata[CNT_W-1:0];
                3'd3: begin
                    if (writedata[0]) ovf_d = 1'b0;
                    if (writedata[1]) udf_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Reads that do not touch memory (CSRs, empty pop, data window in FIFO mode) return the CSR path.
        if (rd_acc) begin
            rdsel_mem_d = mem_re;
            csr_rdata_d = csr_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            thresh_q    <= CNT_W'(IRQ_DEFAULT);
            mode_q      <= 1'b0;
            ie_q        <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdsel_mem_q <= 1'b0;
            csr_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            thresh_q    <= thresh_d;
            mode_q      <= mode_d;
            ie_q        <= ie_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            irq_q       <= irq_d;
            rvalid_q    <= rvalid_d;
            rdsel_mem_q <= rdsel_mem_d;
            csr_rdata_q <= csr_rdata_d;
        end
    end

    assign readdata      = rdsel_mem_q ? mem_rdata_q : csr_rdata_q;
    assign readdatavalid = rvalid_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_avalon_ring_buffer.sv
// Bench for avalon_ring_buffer: register/RAM vector table, FIFO corner sequences,
// and randomized RAM/FIFO traffic against an array/queue reference model.
module tb_avalon_ring_buffer;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    localparam logic [10:0] A_CTRL = 11'h400;
    localparam logic [10:0] A_STAT = 11'h401;
    localparam logic [10:0] A_THR  = 11'h402;
    localparam logic [10:0] A_FCLR = 11'h403;
    localparam logic [10:0] A_FIFO = 11'h404;
    localparam logic [10:0] A_RSV  = 11'h405;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   address;
    logic          chipselect, read, write;
    logic [3:0]    byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid, irq;

    int n_cmp  = 0;
    int n_fail = 0;

    avalon_ring_buffer #(.DATA_W(DW), .ADDR_W(AW), .IRQ_DEFAULT(512)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        $display("WR  addr=%03h data=%08h be=%b", a, d, be);
    endtask

    task automatic bus_rd(input logic [10:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
        v = readdatavalid;
        $display("RD  addr=%03h data=%08h valid=%0b", a, d, v);
    endtask

    task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic v;
        bus_rd(a, d, v);
        check({name, "_valid"}, 32'(v), 32'd1);
        check(name, d, exp);
    endtask

    function automatic logic [31:0] stat(input int n, input bit o, input bit u);
        logic [31:0] s;
        s = 32'(n);
        s[11] = (n == 0);
        s[12] = (n == DEPTH);
        s[13] = o;
        s[14] = u;
        return s;
    endfunction

    function automatic void add(input bit wr, input logic [10:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] d, q_exp;
        logic        v;
        logic [31:0] mem_m [16];
        logic [31:0] q[$];
        logic [31:0] exp_list[$];
        int          errs;
        bit          ovf_m, udf_m;

        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_rvalid", 32'(readdatavalid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Register defaults and RAM-mode behaviour
        add(0, A_STAT, 0, 0, 32'h0000_0800);
        add(0, A_THR,  0, 0, 32'h0000_0200);
        add(0, A_CTRL, 0, 0, 32'h0000_0000);
        add(1, 11'h005, 32'hDEAD_BEEF, 4'b1111, 0);
        add(1, 11'h005, 32'h0000_00AA, 4'b0001, 0);
        add(0, 11'h005, 0, 0, 32'hDEAD_BEAA);
        add(1, 11'h006, 32'h1122_3344, 4'b1111, 0);
        add(1, 11'h006, 32'hAABB_CCDD, 4'b1010, 0);
        add(0, 11'h006, 0, 0, 32'hAA22_CC44);
        add(1, 11'h3FF, 32'hCAFE_F00D, 4'b1111, 0);
        add(0, 11'h3FF, 0, 0, 32'hCAFE_F00D);
        add(0, A_RSV,  0, 0, 32'h0);
        add(1, A_RSV,  32'hFFFF_FFFF, 4'b1111, 0);
        add(0, A_RSV,  0, 0, 32'h0);
        add(0, A_FIFO, 0, 0, 32'h0);
        add(1, A_FIFO, 32'h1234_5678, 4'b1111, 0);
        add(0, A_STAT, 0, 0, 32'h0000_0800);
        add(1, A_THR,  32'hFFFF_FFFF, 4'b1111, 0);
        add(0, A_THR,  0, 0, 32'h0000_07FF);
        add(1, A_THR,  32'h0000_0200, 4'b1111, 0);
        add(0, 11'h005, 0, 0, 32'hDEAD_BEAA);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        tick();
        check("rvalid_one_cycle", 32'(readdatavalid), 32'h0);

        // FIFO basics and underflow
        bus_wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 1; i <= 3; i++) bus_wr(A_FIFO, 32'(i), 4'h0);
        rd_check("fifo_stat3", A_STAT, stat(3, 0, 0));
        for (int i = 1; i <= 3; i++) rd_check($sformatf("fifo_pop%0d", i), A_FIFO, 32'(i));
        rd_check("fifo_stat_empty", A_STAT, stat(0, 0, 0));
        rd_check("fifo_pop_empty", A_FIFO, 32'h0);
        rd_check("fifo_stat_udf", A_STAT, stat(0, 0, 1));
        bus_wr(A_FCLR, 32'h2, 4'hF);
        rd_check("fifo_udf_clr", A_STAT, stat(0, 0, 0));
        rd_check("data_win_fifo_mode", 11'h005, 32'h0);

        // Fill to full, overflow, drain
        bus_wr(A_CTRL, 32'h5, 4'hF);
        exp_list.delete();
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            exp_list.push_back(d);
            bus_wr(A_FIFO, d, 4'h0);
        end
        rd_check("fill_stat_full", A_STAT, stat(DEPTH, 0, 0));
        bus_wr(A_FIFO, 32'h0000_FFFF, 4'hF);
        rd_check("fill_stat_ovf", A_STAT, stat(DEPTH, 1, 0));
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(A_FIFO, d, v);
            if (d !== exp_list[i] || v !== 1'b1) errs++;
        end
        check("fill_drain_errors", 32'(errs), 32'h0);
        rd_check("fill_stat_drained", A_STAT, stat(0, 1, 0));
        bus_wr(A_FCLR, 32'h1, 4'hF);

        // Wrap-around: 1000 in/out, then 50 across the top of the ring
        errs = 0;
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 1000 : 50;
            exp_list.delete();
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                exp_list.push_back(d);
                bus_wr(A_FIFO, d, 4'hF);
            end
            for (int i = 0; i < n; i++) begin
                bus_rd(A_FIFO, d, v);
                if (d !== exp_list[i]) errs++;
            end
        end
        check("wrap_errors", 32'(errs), 32'h0);
        rd_check("wrap_stat", A_STAT, stat(0, 0, 0));

        // Interrupt threshold
        bus_wr(A_THR, 32'h4, 4'hF);
        bus_wr(A_CTRL, 32'h3, 4'hF);
        for (int i = 0; i < 3; i++) bus_wr(A_FIFO, 32'(i + 10), 4'hF);
        tick();
        check("irq_below", 32'(irq), 32'h0);
        bus_wr(A_FIFO, 32'h13, 4'hF);
        check("irq_same_edge", 32'(irq), 32'h0);
        tick();
        check("irq_at_thresh", 32'(irq), 32'h1);
        rd_check("irq_pop", A_FIFO, 32'd10);
        tick();
        check("irq_after_pop", 32'(irq), 32'h0);
        bus_wr(A_FIFO, 32'h14, 4'hF);
        tick();
        check("irq_refill", 32'(irq), 32'h1);
        bus_wr(A_CTRL, 32'h7, 4'hF);
        tick();
        check("irq_flush", 32'(irq), 32'h0);
        rd_check("flush_stat", A_STAT, stat(0, 0, 0));
        rd_check("flush_ctrl", A_CTRL, 32'h3);
        bus_wr(A_THR, 32'h0, 4'hF);
        tick();
        check("irq_thresh0", 32'(irq), 32'h1);
        bus_wr(A_CTRL, 32'h1, 4'hF);
        tick();
        check("irq_ie_off", 32'(irq), 32'h0);

        // Random RAM traffic against an array model
        bus_wr(A_CTRL, 32'h0, 4'hF);
        for (int a = 0; a < 16; a++) begin
            mem_m[a] = $urandom;
            bus_wr(11'(a), mem_m[a], 4'hF);
        end
        for (int i = 0; i < 200; i++) begin
            int a;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                logic [3:0] be;
                be = 4'($urandom);
                d = $urandom;
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
                bus_wr(11'(a), d, be);
            end else begin
                rd_check($sformatf("ram_rand%0d", i), 11'(a), mem_m[a]);
            end
        end

        // Random FIFO traffic against a queue model
        bus_wr(A_CTRL, 32'h5, 4'hF);
        bus_wr(A_FCLR, 32'h3, 4'hF);
        q.delete(); ovf_m = 0; udf_m = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                d = $urandom;
                if (q.size() < DEPTH) q.push_back(d);
                else ovf_m = 1;
                bus_wr(A_FIFO, d, 4'($urandom));
            end else if (r < 9) begin
                if (q.size() > 0) q_exp = q.pop_front();
                else begin
                    q_exp = 0;
                    udf_m = 1;
                end
                rd_check($sformatf("fifo_rand%0d", i), A_FIFO, q_exp);
            end else begin
                rd_check($sformatf("fifo_rstat%0d", i), A_STAT, stat(q.size(), ovf_m, udf_m));
            end
        end
        rd_check("fifo_rand_final", A_STAT, stat(q.size(), ovf_m, udf_m));

        // Asynchronous reset right after a pop
        bus_wr(A_THR, 32'h9, 4'hF);
        bus_wr(A_FIFO, 32'h55, 4'hF);
        bus_rd(A_FIFO, d, v);
        check("pre_reset_rvalid", 32'(v), 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(readdatavalid), 32'h0);
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_rvalid", 32'(readdatavalid), 32'h0);
        rd_check("post_rst_stat", A_STAT, stat(0, 0, 0));
        rd_check("post_rst_ctrl", A_CTRL, 32'h0);
        rd_check("post_rst_thr", A_THR, 32'd512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
